// File: rtl/alsu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alsu_cmd_driver
// Brief    : Initiator for one ALSU instance. Each accepted host command is
//            registered onto the ALSU pins for exactly one cycle. The command
//            is tracked through the ALSU pipeline, and the captured result is
//            queued in a first-word-fall-through response FIFO. Command
//            acceptance is credit based, so the FIFO can never overflow.
// Revision : 1.0 - initial release
// ============================================================================
module alsu_cmd_driver #(
   parameter int LATENCY    = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   // host command channel
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_a,
   input  logic [2:0]  cmd_b,
   input  logic [2:0]  cmd_opcode,
   input  logic        cmd_cin,
   input  logic        cmd_serial_in,
   input  logic        cmd_direction,
   input  logic        cmd_red_op_a,
   input  logic        cmd_red_op_b,
   input  logic        cmd_bypass_a,
   input  logic        cmd_bypass_b,
   // ALSU pins
   output logic [2:0]  alsu_a,
   output logic [2:0]  alsu_b,
   output logic [2:0]  alsu_opcode,
   output logic        alsu_cin,
   output logic        alsu_serial_in,
   output logic        alsu_direction,
   output logic        alsu_red_op_a,
   output logic        alsu_red_op_b,
   output logic        alsu_bypass_a,
   output logic        alsu_bypass_b,
   input  logic [5:0]  alsu_out,
   input  logic [15:0] alsu_leds,
   // host response channel
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [5:0]  rsp_out,
   output logic [15:0] rsp_leds,
   output logic        busy
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_SUM_W = c_CNT_W + 4;
   localparam int c_ENT_W = 22;

   logic [LATENCY-1:0] r_track;
   logic [c_CNT_W-1:0] r_count;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];

   logic               w_accept;
   logic               w_push;
   logic               w_pop;
   logic [3:0]         w_inflight;
   logic [c_SUM_W-1:0] w_credit;
   logic [c_PTR_W-1:0] w_rd_ptr_inc;
   logic [c_ENT_W-1:0] w_push_data;
   logic [c_ENT_W-1:0] w_head_data;
   logic               w_head_load;

   // Credits come from registered state only; a same-cycle pop is not counted.
   assign w_credit     = c_SUM_W'(r_count) + c_SUM_W'(w_inflight);
   assign cmd_ready    = (w_credit < c_SUM_W'(FIFO_DEPTH));
   assign w_accept     = cmd_valid & cmd_ready;
   assign rsp_valid    = (r_count != '0);
   assign w_pop        = rsp_valid & rsp_ready;
   assign w_push       = r_track[LATENCY-1];
   assign w_push_data  = {alsu_out, alsu_leds};
   assign w_rd_ptr_inc = r_rd_ptr + c_PTR_W'(1);
   assign busy         = (r_track != '0) || (r_count != '0);

   // Count the commands still travelling through the ALSU pipeline.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         w_inflight = w_inflight + 4'(r_track[i]);
      end
   end

   // Present an accepted command for one cycle; otherwise drive the idle pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alsu_a         <= '0;
         alsu_b         <= '0;
         alsu_opcode    <= '0;
         alsu_cin       <= 1'b0;
         alsu_serial_in <= 1'b0;
         alsu_direction <= 1'b0;
         alsu_red_op_a  <= 1'b0;
         alsu_red_op_b  <= 1'b0;
         alsu_bypass_a  <= 1'b0;
         alsu_bypass_b  <= 1'b0;
      end else if (w_accept) begin
         alsu_a         <= cmd_a;
         alsu_b         <= cmd_b;
         alsu_opcode    <= cmd_opcode;
         alsu_cin       <= cmd_cin;
         alsu_serial_in <= cmd_serial_in;
         alsu_direction <= cmd_direction;
         alsu_red_op_a  <= cmd_red_op_a;
         alsu_red_op_b  <= cmd_red_op_b;
         alsu_bypass_a  <= cmd_bypass_a;
         alsu_bypass_b  <= cmd_bypass_b;
      end else begin
         alsu_a         <= '0;
         alsu_b         <= '0;
         alsu_opcode    <= '0;
         alsu_cin       <= 1'b0;
         alsu_serial_in <= 1'b0;
         alsu_direction <= 1'b0;
         alsu_red_op_a  <= 1'b0;
         alsu_red_op_b  <= 1'b0;
         alsu_bypass_a  <= 1'b0;
         alsu_bypass_b  <= 1'b0;
      end
   end

   // Pipeline tracker: a bit leaving the last stage marks the capture edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_track <= '0;
      end else begin
         r_track <= (r_track << 1) | LATENCY'(w_accept);
      end
   end

   // Response FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Response storage; contents are only meaningful under the occupancy count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   // Select the entry that becomes the head after this edge, if the head changes.
   always_comb begin
      w_head_load = 1'b0;
      w_head_data = r_mem[r_rd_ptr];
      if (w_pop) begin
         if (r_count > c_CNT_W'(1)) begin
            w_head_load = 1'b1;
            w_head_data = r_mem[w_rd_ptr_inc];
         end else if (w_push) begin
            w_head_load = 1'b1;
            w_head_data = w_push_data;
         end
      end else if ((r_count == '0) && w_push) begin
         w_head_load = 1'b1;
         w_head_data = w_push_data;
      end
   end

   // Registered head so the response outputs keep their last value when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_out  <= '0;
         rsp_leds <= '0;
      end else if (w_head_load) begin
         {rsp_out, rsp_leds} <= w_head_data;
      end
   end

endmodule
`default_nettype wire
